// File: rtl/fifo_vc_arbiter_if.sv
// fifo_vc_arbiter_if: FIFO-side signal bundle between the arbiter (master) and the FIFO datapath (slave).
interface fifo_vc_arbiter_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  init;
    logic [3:0]            umbral_vc_in;
    logic [3:0]            umbral_d_in;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  d0_full;
    logic                  d1_full;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  fifo_error;
    logic                  vc0_rd_enable;
    logic                  vc1_rd_enable;
    logic                  d0_wr_enable;
    logic                  d1_wr_enable;
    logic [DATA_WIDTH-1:0] d_data_out;
    logic                  fifo_init;
    logic [3:0]            umbral_vc;
    logic [3:0]            umbral_d;
    logic [1:0]            state;
    logic                  error;

    modport master (
        input  init, umbral_vc_in, umbral_d_in, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_full, d1_full, d0_almost_full, d1_almost_full, fifo_error,
        output vc0_rd_enable, vc1_rd_enable, d0_wr_enable, d1_wr_enable, d_data_out,
               fifo_init, umbral_vc, umbral_d, state, error
    );

    modport slave (
        output init, umbral_vc_in, umbral_d_in, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_full, d1_full, d0_almost_full, d1_almost_full, fifo_error,
        input  vc0_rd_enable, vc1_rd_enable, d0_wr_enable, d1_wr_enable, d_data_out,
               fifo_init, umbral_vc, umbral_d, state, error
    );
endinterface

// File: rtl/fifo_vc_arbiter.sv
// fifo_vc_arbiter: sequences VC/destination FIFOs and pops VC0 over VC1 into D0/D1; VC_FAIR_ARB_EN adds VC1 anti-starvation.
module fifo_vc_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT = 4
) (
    input logic               clk,
    input logic               reset,
    fifo_vc_arbiter_if.master bus
);
    typedef enum logic [1:0] {RESET = 2'd0, INIT = 2'd1, IDLE = 2'd2, ACTIVE = 2'd3} state_t;

    state_t                state_q, state_d;
    logic                  fifo_init_q, error_q, pop_v, pop_src;
    logic                  stall, vc1_turn, vc0_rd, vc1_rd, d0_wr, d1_wr;
    logic [3:0]            umbral_vc_q, umbral_d_q;
    logic [DATA_WIDTH-1:0] word;

`ifdef VC_FAIR_ARB_EN
    logic [1:0] fair_cnt;
    logic       owe;
    // Count VC0 wins against a waiting VC1; after four, VC1 is owed the next grant.
    always_ff @(posedge clk) begin
        if (reset || bus.vc1_empty || vc1_rd) begin
            fair_cnt <= '0;
            owe <= 1'b0;
        end else if (vc0_rd) begin
            fair_cnt <= fair_cnt + 2'd1;
            owe <= fair_cnt == 2'd3;
        end
    end
    assign vc1_turn = owe && !bus.vc1_empty;
`else
    assign vc1_turn = 1'b0;
`endif

    // Next state: init preempts everything; ACTIVE only retires once the last popped word is pushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = INIT;
            INIT:    state_d = bus.init ? INIT : IDLE;
            IDLE:    state_d = bus.init ? INIT : (!bus.vc0_empty || !bus.vc1_empty) ? ACTIVE : IDLE;
            default: state_d = bus.init ? INIT : (bus.vc0_empty && bus.vc1_empty && !pop_v) ? IDLE : ACTIVE;
        endcase
    end

    // Pop grants and the registered-pop push decode.
    always_comb begin
        stall = bus.d0_full || bus.d1_full || bus.d0_almost_full || bus.d1_almost_full;
        vc0_rd = state_q == ACTIVE && !bus.vc0_empty && !stall && !vc1_turn;
        vc1_rd = state_q == ACTIVE && !bus.vc1_empty && !stall && (bus.vc0_empty || vc1_turn);
        word = pop_src ? bus.vc1_data : bus.vc0_data;
        d0_wr = pop_v && !word[DEST_BIT];
        d1_wr = pop_v && word[DEST_BIT];
    end

    // State, thresholds, pop tracking and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET;
            fifo_init_q <= 1'b0;
            umbral_vc_q <= '0;
            umbral_d_q <= '0;
            error_q <= 1'b0;
            pop_v <= 1'b0;
            pop_src <= 1'b0;
        end else begin
            state_q <= state_d;
            fifo_init_q <= state_d == IDLE || state_d == ACTIVE;
            umbral_vc_q <= state_q == INIT ? bus.umbral_vc_in : umbral_vc_q;
            umbral_d_q <= state_q == INIT ? bus.umbral_d_in : umbral_d_q;
            pop_v <= vc0_rd || vc1_rd;
            pop_src <= vc1_rd;
            error_q <= (state_d == INIT && state_q != INIT) ? 1'b0 :
                       error_q || bus.fifo_error || (d0_wr && bus.d0_full) || (d1_wr && bus.d1_full);
        end
    end

    assign bus.vc0_rd_enable = vc0_rd;
    assign bus.vc1_rd_enable = vc1_rd;
    assign bus.d0_wr_enable = d0_wr;
    assign bus.d1_wr_enable = d1_wr;
    assign bus.d_data_out = pop_v ? word : '0;
    assign bus.fifo_init = fifo_init_q;
    assign bus.umbral_vc = umbral_vc_q;
    assign bus.umbral_d = umbral_d_q;
    assign bus.state = state_q;
    assign bus.error = error_q;
endmodule

// File: doc/fifo_vc_arbiter.md
# fifo_vc_arbiter

Sequencing controller and arbiter for the transmit-layer FIFO datapath. It holds the virtual-channel (VC) FIFOs and downstream FIFOs in init while thresholds are configured, then runs them. It pops words from two source VC FIFOs under strict priority, with VC0 above VC1, and routes each popped word to destination FIFO D0 or D1 according to a destination bit in the word. Pops are gated by destination back-pressure.

## Interface
- `DATA_WIDTH`, 6, word width of the VC and destination FIFOs.
- `DEST_BIT`, 4, bit index of the word that selects the destination: 0 selects D0, 1 selects D1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `init` in 1: configuration request, level-sensitive.
- `umbral_vc_in`, `umbral_d_in` in 4: threshold values latched while configuring.
- `vc0_empty`, `vc1_empty` in 1: source FIFO empty flags.
- `vc0_data`, `vc1_data` in DATA_WIDTH: registered source FIFO outputs, valid the cycle after a read.
- `d0_full`, `d1_full`, `d0_almost_full`, `d1_almost_full` in 1: destination FIFO flags.
- `fifo_error` in 1: OR of all FIFO error flags.
- `vc0_rd_enable`, `vc1_rd_enable` out 1: source pops.
- `d0_wr_enable`, `d1_wr_enable` out 1: destination pushes.
- `d_data_out` out DATA_WIDTH: word presented to both destination FIFOs.
- `fifo_init` out 1: run enable for all FIFOs; 0 holds them cleared.
- `umbral_vc`, `umbral_d` out 4: registered thresholds driven to the VC and destination FIFOs.
- `state` out 2: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- `error` out 1: sticky error.

## Operation
**State machine (registered)**
- RESET → INIT, unconditionally on the next edge.
- INIT → IDLE when `init`=0. While in INIT, `umbral_vc`/`umbral_d` load from the `_in` ports every cycle.
- IDLE → INIT if `init`=1. Otherwise IDLE → ACTIVE if `vc0_empty`=0 or `vc1_empty`=0.
- ACTIVE → INIT if `init`=1. Otherwise ACTIVE → IDLE if both empty flags are 1 and no pop is in flight.
- `init` has priority over every other transition.

**Control outputs**
- `fifo_init` = 1 only in IDLE and ACTIVE (registered decode of `state`).

**Pop logic (combinational from current state and inputs)**
- `stall` = `d0_full` | `d1_full` | `d0_almost_full` | `d1_almost_full`.
- `vc0_rd_enable` = ACTIVE & !`vc0_empty` & !`stall`.
- `vc1_rd_enable` = ACTIVE & `vc0_empty` & !`vc1_empty` & !`stall`.
- At most one rd_enable is high per cycle.

**Push logic**
- `pop_v`/`pop_src` register the pop.
- In the next cycle, the word is `vc0_data` or `vc1_data` per `pop_src`.
- `d_data_out` = that word when `pop_v`=1, else 0.
- `d0_wr_enable` = `pop_v` & !word[`DEST_BIT`]; `d1_wr_enable` = `pop_v` & word[`DEST_BIT`].

**Error**
- `error` sets on `fifo_error`=1.
- `error` also sets on a push while the target FIFO's full flag is 1.
- `error` clears only on `reset` or on entry to INIT.

**Reset values**
- `state`=RESET, `umbral_vc`=`umbral_d`=0, `fifo_init`=0, `error`=0.
- `pop_v`=0, so all rd/wr enables are 0 and `d_data_out`=0.

## Timing
- Pop-to-push latency: exactly 1 cycle. A pop at edge n produces a push at edge n+1.
- Sustained throughput: one word per cycle while unstalled.
- A stall blocks new pops only. The in-flight word is always pushed; the almost-full margin (≥1) absorbs it.
- Leaving ACTIVE to INIT drops the in-flight word, because `fifo_init`=0 clears the FIFOs the next cycle.
- `reset` mid-operation clears everything in the same edge and discards any in-flight push.
- ACTIVE→IDLE requires `pop_v`=0, so the last word is pushed before IDLE.
- Thresholds are stable outside INIT. Changes on the `_in` ports are ignored in IDLE and ACTIVE.

## Configuration
- `VC_FAIR_ARB_EN` defined: a 2-bit counter tracks consecutive VC0 grants while `vc1_empty`=0.
  - After 4 such grants, the next unstalled cycle grants VC1 (if non-empty) and the counter resets.
  - The counter also resets on any VC1 grant or when `vc1_empty`=1.
- `VC_FAIR_ARB_EN` undefined: strict priority; VC1 can starve indefinitely.

## Test plan
- Reset, then `init`=1 for 3 cycles with `umbral_vc_in`=2, `umbral_d_in`=1, then `init`=0 → state RESET→INIT→IDLE; `umbral_vc`=2, `umbral_d`=1; `fifo_init` rises in IDLE.
- VC0 holds 0x05 (bit4=0), then 0x15 (bit4=1) → `vc0_rd_enable` high 2 cycles. Next cycles: `d0_wr_enable` with 0x05, then `d1_wr_enable` with 0x15. Then return to IDLE.
- Both VCs non-empty with 3 words each, strict build → 3 VC0 pops, then 3 VC1 pops, back-to-back.
- Same stimulus with `VC_FAIR_ARB_EN` and VC0 holding 8 words → grant order 0,0,0,0,1,0,0,0,0,1,…
- `d1_almost_full`=1 mid-burst → no rd_enable while high; the in-flight word is still pushed; no `error`. Force `d0_full`=1 during a push to D0 → `error`=1, held until INIT.
- Assert `reset` on the edge after a pop → all enables 0 next cycle; no push occurs; state=RESET.
